i2c_ads1115_target: RTL and testbench

- I2C target (responder) that emulates the ADS1115 register map on the SDA/SCL pins.
- The bench and the bring-up design use it as the far end of the ADS1115 initiator. It also lets another FPGA board stand in for the ADC.
- It decodes the address, pointer and register traffic from the bus and drives ACK and read data open-drain.
- It exposes the config register and accepts conversion results from fabric.

---
 rtl/i2c_ads1115_target.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_ads1115_target.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ads1115_target.sv
// I2C target that answers like an ADS1115: a pointer register plus four
// 16-bit registers (conversion, config, lo/hi threshold), with open-drain SDA.
// The conversion register is supplied from fabric and the config register
// is exposed with a one-cycle update strobe.
module i2c_ads1115_target #(
  parameter logic [6:0]  DEV_ADDR      = 7'b1001000,
  parameter logic [15:0] CONFIG_RST    = 16'h8583,
  parameter logic [15:0] LO_THRESH_RST = 16'h8000,
  parameter logic [15:0] HI_THRESH_RST = 16'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] conv_data,
  output logic [15:0] config_out,
  output logic        config_wr,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WR_PTR, S_WR_MSB, S_WR_LSB,
    S_ACK_WAIT, S_ACK_OUT, S_RD_BYTE, S_RD_ACK, S_RD_NEXT, S_IGNORE
  } state_t;

  state_t      state, resume;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [6:0]  rx_shift;
  logic [6:0]  tx_shift;
  logic [3:0]  bit_cnt;
  logic [1:0]  pointer;
  logic [7:0]  msb_buf;
  logic [15:0] lo_thresh, hi_thresh;
  logic [15:0] snap;
  logic        lsb_next;

  logic        scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]  rx_byte;
  logic [7:0]  next_byte;
  logic [15:0] rd_src;

  // Two-flop synchronizers plus one history flop per pin for edge detection.
  // NOTE: the sync chain resets to 1 (idle bus level) so leaving reset on a
  // quiet bus does not look like a falling edge or a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what turns this into a shift chain.
      {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
    end
  end

  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte    = {rx_shift, sda_s2};

  // Read source selected by the pointer, and the byte to send after a master ACK.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_src    = conv_data;
    next_byte = snap[15:8];
    case (pointer)
      2'b01:   rd_src = config_out;
      2'b10:   rd_src = lo_thresh;
      2'b11:   rd_src = hi_thresh;
      default: rd_src = conv_data;
    endcase
    if (lsb_next) next_byte = snap[7:0];
  end

  // Protocol FSM: bus conditions, byte reception, ACK drive and read shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      resume     <= S_IDLE;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      config_out <= CONFIG_RST;
      config_wr  <= 1'b0;
      lo_thresh  <= LO_THRESH_RST;
      hi_thresh  <= HI_THRESH_RST;
      pointer    <= 2'b00;
      rx_shift   <= '0;
      tx_shift   <= '0;
      bit_cnt    <= '0;
      msb_buf    <= '0;
      snap       <= '0;
      lsb_next   <= 1'b0;
    end else begin
      config_wr <= 1'b0;
      if (start_cond) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_cond) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_WR_PTR, S_WR_MSB, S_WR_LSB: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                state   <= S_ACK_WAIT;
                case (state)
                  S_ADDR: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      resume <= rx_byte[0] ? S_RD_BYTE : S_WR_PTR;
                    end else begin
                      state <= S_IGNORE;
                      busy  <= 1'b0;
                    end
                  end
                  S_WR_PTR: begin
                    pointer <= rx_byte[1:0];
                    resume  <= S_WR_MSB;
                  end
                  S_WR_MSB: begin
                    msb_buf <= rx_byte;
                    resume  <= S_WR_LSB;
                  end
                  default: begin
                    // Commit on the 8th rising edge of the LSB; pointer 00 is read-only.
                    resume <= S_WR_MSB;
                    case (pointer)
                      2'b01: begin
                        config_out <= {msb_buf, rx_byte};
                        config_wr  <= 1'b1;
                      end
                      2'b10:   lo_thresh <= {msb_buf, rx_byte};
                      2'b11:   hi_thresh <= {msb_buf, rx_byte};
                      default: ;
                    endcase
                  end
                endcase
              end
            end
          end
          S_ACK_WAIT: begin
            if (scl_fall) begin
              sda_oe <= 1'b1;
              state  <= S_ACK_OUT;
            end
          end
          S_ACK_OUT: begin
            if (scl_fall) begin
              if (resume == S_RD_BYTE) begin
                // Snapshot taken as the address ACK ends; later conv_data changes are ignored.
                snap     <= rd_src;
                tx_shift <= rd_src[14:8];
                sda_oe   <= ~rd_src[15];
                bit_cnt  <= 4'd1;
                lsb_next <= 1'b1;
                state    <= S_RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= resume;
              end
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_RD_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end else begin
                state <= S_RD_NEXT;
              end
            end
          end
          S_RD_NEXT: begin
            if (scl_fall) begin
              sda_oe   <= ~next_byte[7];
              tx_shift <= next_byte[6:0];
              bit_cnt  <= 4'd1;
              lsb_next <= ~lsb_next;
              state    <= S_RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_ads1115_target.sv
// Directed bench: a bit-banged I2C master drives the target through register
// writes, reads, repeated START, address mismatch, snapshot and reset corners.
module tb_i2c_ads1115_target;

  localparam int Q = 50; // quarter SCL period in ns (SCL = clk/20)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [15:0] conv_data = 16'h0000;
  logic [15:0] config_out;
  logic        config_wr;
  logic        busy;
  wire         sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_ads1115_target dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_m),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .conv_data  (conv_data),
    .config_out (config_out),
    .config_wr  (config_wr),
    .busy       (busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   wr_pulses = 0;
  int   oe_cycles = 0;
  int   hi_viol = 0;
  logic oe_prev = 1'b0;

  // Bus monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (config_wr) wr_pulses++;
    if (sda_oe) oe_cycles++;
    if (sda_oe && !oe_prev && scl_m) hi_viol++;
    oe_prev = sda_oe;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic reg_write(input logic [1:0] ptr, input logic [15:0] data, output logic [3:0] acks);
    i2c_start;
    write_byte(8'h90, acks[3]);
    write_byte({6'd0, ptr}, acks[2]);
    write_byte(data[15:8], acks[1]);
    write_byte(data[7:0], acks[0]);
    i2c_stop;
  endtask

  task automatic set_ptr(input logic [1:0] ptr, output logic [1:0] acks);
    i2c_start;
    write_byte(8'h90, acks[1]);
    write_byte({6'd0, ptr}, acks[0]);
    i2c_stop;
  endtask

  task automatic reg_read(output logic [15:0] d, output logic acked);
    i2c_start;
    write_byte(8'h91, acked);
    read_byte(d[15:8], 1'b0);
    read_byte(d[7:0], 1'b1);
    i2c_stop;
  endtask

  typedef struct {
    logic [1:0]  ptr;
    logic [15:0] wdata;
    logic [15:0] conv;
    logic [15:0] exp_rd;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [3:0]  a4;
    logic [1:0]  a2;
    logic        a;
    logic        b;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [15:0] cfg_model;
    int          p0;
    int          o0;

    vecs[0] = '{2'b01, 16'h1234, 16'h0000, 16'h1234, 1};
    vecs[1] = '{2'b10, 16'h00F1, 16'h0000, 16'h00F1, 0};
    vecs[2] = '{2'b11, 16'hFFFE, 16'h0000, 16'hFFFE, 0};
    vecs[3] = '{2'b00, 16'h5A5A, 16'hC3A5, 16'hC3A5, 0};
    vecs[4] = '{2'b01, 16'h8001, 16'h0000, 16'h8001, 1};

    // Reset state
    #100;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_config", {16'd0, config_out}, 32'h8583);
    check("rst_config_wr", {31'd0, config_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #100;

    // Repeated START: pointer to config, Sr, read back reset value, no strobe
    p0 = wr_pulses;
    i2c_start;
    write_byte(8'h90, a4[1]);
    write_byte(8'h01, a4[0]);
    check("sr_busy", {31'd0, busy}, 32'd1);
    i2c_start;
    write_byte(8'h91, a);
    read_byte(d16[15:8], 1'b0);
    read_byte(d16[7:0], 1'b1);
    i2c_stop;
    check("sr_acks", {29'd0, a4[1:0], a}, 32'h7);
    check("sr_data", {16'd0, d16}, 32'h8583);
    check("sr_pulses", wr_pulses - p0, 0);

    // Partial write: MSB only, then STOP
    p0 = wr_pulses;
    i2c_start;
    write_byte(8'h90, a4[2]);
    write_byte(8'h01, a4[1]);
    write_byte(8'hAA, a4[0]);
    i2c_stop;
    check("partial_pulses", wr_pulses - p0, 0);
    check("partial_config", {16'd0, config_out}, 32'h8583);

    // Config write
    p0 = wr_pulses;
    reg_write(2'b01, 16'hC483, a4);
    check("cfg_acks", {28'd0, a4}, 32'hF);
    check("cfg_value", {16'd0, config_out}, 32'hC483);
    check("cfg_pulses", wr_pulses - p0, 1);
    check("cfg_busy_after_stop", {31'd0, busy}, 32'd0);

    // Pointer write then read of conversion register
    conv_data = 16'h1234;
    set_ptr(2'b00, a2);
    check("ptr0_acks", {30'd0, a2}, 32'h3);
    i2c_start;
    write_byte(8'h91, a);
    read_byte(d16[15:8], 1'b0);
    read_byte(d16[7:0], 1'b1);
    check("rd_nack_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rd_nack_busy", {31'd0, busy}, 32'd0);
    i2c_stop;
    check("rd_addr_ack", {31'd0, a}, 32'd1);
    check("rd_data", {16'd0, d16}, 32'h1234);

    // Address mismatch
    o0 = oe_cycles;
    i2c_start;
    write_byte(8'h38, a4[3]);
    check("mis_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h01, a4[2]);
    write_byte(8'h12, a4[1]);
    write_byte(8'h34, a4[0]);
    i2c_stop;
    check("mis_acks", {28'd0, a4}, 32'h0);
    check("mis_oe_cycles", oe_cycles - o0, 0);
    check("mis_config", {16'd0, config_out}, 32'hC483);

    // Snapshot: conv_data changes in the middle of the MSB
    conv_data = 16'hABCD;
    i2c_start;
    write_byte(8'h91, a);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d16[8+i] = b;
      if (i == 5) conv_data = 16'h0000;
    end
    write_bit(1'b0);
    read_byte(d16[7:0], 1'b1);
    i2c_stop;
    check("snap_data", {16'd0, d16}, 32'hABCD);

    // Reset while the target drives a 0 data bit
    conv_data = 16'h0F0F;
    i2c_start;
    write_byte(8'h91, a);
    check("rstmid_oe_before", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_oe", {31'd0, sda_oe}, 32'd0);
    check("rstmid_config", {16'd0, config_out}, 32'h8583);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    #9;
    rst = 1'b0;
    #20;
    i2c_stop;
    reg_read(d16, a);
    check("post_rst_ack", {31'd0, a}, 32'd1);
    check("post_rst_data", {16'd0, d16}, 32'h0F0F);
    set_ptr(2'b10, a2);
    reg_read(d16, a);
    check("lo_thresh_rst", {16'd0, d16}, 32'h8000);
    set_ptr(2'b11, a2);
    reg_read(d16, a);
    check("hi_thresh_rst", {16'd0, d16}, 32'h7FFF);

    // Table: write each register, then read it back through the pointer
    cfg_model = 16'h8583;
    for (int i = 0; i < 5; i++) begin
      conv_data = vecs[i].conv;
      p0 = wr_pulses;
      reg_write(vecs[i].ptr, vecs[i].wdata, a4);
      if (vecs[i].ptr == 2'b01) cfg_model = vecs[i].wdata;
      check($sformatf("vec%0d_acks", i), {28'd0, a4}, 32'hF);
      check($sformatf("vec%0d_pulses", i), wr_pulses - p0, vecs[i].exp_pulses);
      check($sformatf("vec%0d_config", i), {16'd0, config_out}, {16'd0, cfg_model});
      set_ptr(vecs[i].ptr, a2);
      reg_read(d16, a);
      check($sformatf("vec%0d_read", i), {15'd0, a, d16}, {15'd0, 1'b1, vecs[i].exp_rd});
    end

    // Two byte pairs in one write transaction rewrite the same register
    p0 = wr_pulses;
    i2c_start;
    write_byte(8'h90, a4[3]);
    write_byte(8'h01, a4[2]);
    write_byte(8'h11, a4[1]);
    write_byte(8'h22, a4[0]);
    write_byte(8'h33, a);
    write_byte(8'h44, b);
    i2c_stop;
    check("multi_acks", {26'd0, a4, a, b}, 32'h3F);
    check("multi_pulses", wr_pulses - p0, 2);
    check("multi_config", {16'd0, config_out}, 32'h3344);

    check("oe_rise_while_scl_high", hi_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
